rsa_mont_share_arb: RTL and testbench

//  Round-robin scheduler sharing one 256-bit Montgomery multiplier between NUM_REQ requesters
//  (e.g. the square path and multiply path of the RSA exponentiation loop). Latches the winner's

---
 rtl/rsa_mont_share_arb_pkg.sv | 12 +
 rtl/rsa_mont_share_arb_if.sv | 23 ++
 rtl/rsa_mont_share_arb_rr_pick.sv | 34 +++
 rtl/rsa_mont_share_arb.sv | 132 +++++++++++++
 tb/tb_rsa_mont_share_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_mont_share_arb_pkg.sv
// Shared types and constants for the Montgomery multiplier share arbiter.
package rsa_mont_share_arb_pkg;

  localparam int RSA_W = 256;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rsa_mont_share_arb_if.sv
// Arbiter-to-multiplier link: operands and start toward the multiplier, result and done back.
interface rsa_mont_share_arb_if #(
  parameter int WIDTH = 256
);
  // mont_start is a one-cycle pulse; mont_n/a/b are stable from start until mont_done;
  // mont_m is valid only in the cycle mont_done is high.
  logic             mont_start;
  logic [WIDTH-1:0] mont_n;
  logic [WIDTH-1:0] mont_a;
  logic [WIDTH-1:0] mont_b;
  logic             mont_done;
  logic [WIDTH-1:0] mont_m;

  modport master (
    output mont_start, mont_n, mont_a, mont_b,
    input  mont_done, mont_m
  );

  modport slave (
    input  mont_start, mont_n, mont_a, mont_b,
    output mont_done, mont_m
  );
endinterface

// File: rtl/rsa_mont_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping past NUM_REQ-1.
module rsa_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [IW:0]        sum;
  logic               found;

  always_comb begin
    // rot[i] is requester (ptr + i) mod NUM_REQ, so the lowest set bit is the winner.
    rot   = NUM_REQ'({req, req} >> ptr);
    sum   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(i);
      end
    end
    if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    idx   = sum[IW-1:0];
    any   = found;
    grant = found ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/rsa_mont_share_arb.sv
// Round-robin owner of one shared Montgomery multiplier: grant, issue, wait with watchdog, return.
module rsa_mont_share_arb
  import rsa_mont_share_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int WIDTH       = RSA_W,
  parameter int TIMEOUT_CYC = 300
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_b,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_err,
  output logic [WIDTH-1:0]         o_result,
  output logic                     o_busy,
  output arb_state_t               o_state,
  rsa_mont_share_arb_if.master     mont
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      ptr_q, owner_q, pick_idx, ptr_next;
  logic [WW-1:0]      wdog_q;
  logic [NUM_REQ-1:0] pick_grant, ack_q, done_q;
  logic               pick_any, take, finish, err_q, start_q;
  logic [WIDTH-1:0]   result_q, n_q, a_q, b_q, a_sel, b_sel;

  rsa_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IW'(k)) begin
        a_sel = i_a[k*WIDTH +: WIDTH];
        b_sel = i_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Explicit wrap since NUM_REQ need not be a power of two.
  assign ptr_next = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_ISSUE;
          take    = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A done arriving on the expiry cycle still counts as a normal completion.
        if (mont.mont_done || (wdog_q == WW'(TIMEOUT_CYC - 1))) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      wdog_q   <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      result_q <= '0;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      if (take) begin
        n_q     <= i_n;
        a_q     <= a_sel;
        b_q     <= b_sel;
        owner_q <= pick_idx;
        ack_q   <= pick_grant;
      end
      if (state_q == S_ISSUE) begin
        start_q <= 1'b1;
        wdog_q  <= '0;
      end else if ((state_q == S_WAIT) && (wdog_q != WW'(TIMEOUT_CYC))) begin
        wdog_q <= wdog_q + 1'b1;
      end
      if (finish) begin
        done_q   <= NUM_REQ'(1) << owner_q;
        err_q    <= !mont.mont_done;
        result_q <= mont.mont_done ? mont.mont_m : '0;
        ptr_q    <= ptr_next;
      end
    end
  end

  assign o_ack           = ack_q;
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign o_result        = result_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_state         = state_q;
  assign mont.mont_start = start_q;
  assign mont.mont_n     = n_q;
  assign mont.mont_a     = a_q;
  assign mont.mont_b     = b_q;

endmodule

// File: tb/tb_rsa_mont_share_arb.sv
// Bench for rsa_mont_share_arb with an XOR stub multiplier of configurable latency.
module tb_rsa_mont_share_arb;
  import rsa_mont_share_arb_pkg::*;

  localparam int N     = 2;
  localparam int W     = 256;
  localparam int TO    = 300;
  localparam int ENT_W = 1 + N + W;

  // ---------------- clock / reset ----------------
  logic clk, rst;
  int   cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [W-1:0]   n_in;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus, b_bus;
  logic [N-1:0]   ack, done;
  logic           err, busy;
  logic [W-1:0]   result;
  arb_state_t     state;

  rsa_mont_share_arb_if #(.WIDTH(W)) mif ();

  rsa_mont_share_arb #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_n      (n_in),
    .i_req    (req),
    .i_a      (a_bus),
    .i_b      (b_bus),
    .o_ack    (ack),
    .o_done   (done),
    .o_err    (err),
    .o_result (result),
    .o_busy   (busy),
    .o_state  (state),
    .mont     (mif)
  );

  // ---------------- stub multiplier ----------------
  int           lat = 10;
  bit           never_done = 1'b0;
  bit           stub_run;
  int           stub_cnt;
  logic         stub_done, spur_done;
  logic [W-1:0] stub_m, spur_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_run  <= 1'b0;
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_m    <= '0;
    end else begin
      stub_done <= 1'b0;
      if (mif.mont_start) begin
        stub_run <= 1'b1;
        stub_cnt <= 1;
      end else if (stub_run) begin
        if (stub_cnt == lat - 1) begin
          stub_run <= 1'b0;
          if (!never_done) begin
            stub_done <= 1'b1;
            stub_m    <= mif.mont_a ^ mif.mont_b;
          end
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
      end
    end
  end

  assign mif.mont_done = stub_done | spur_done;
  assign mif.mont_m    = spur_done ? spur_m : stub_m;

  // ---------------- requester drivers ----------------
  int           jobs_left [N];
  logic [W-1:0] a_val [N];
  logic [W-1:0] b_val [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign a_bus[g*W +: W] = a_val[g];
    assign b_bus[g*W +: W] = b_val[g];
  end

  initial begin
    req = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (req[k] && ack[k]) begin
          req[k] = 1'b0;
          jobs_left[k]--;
        end else if (!req[k] && jobs_left[k] > 0 && !rst) begin
          req[k] = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [ENT_W-1:0] exp_q[$];
  logic [N-1:0]     exp_ack_q[$];
  int checks = 0, errors = 0, done_seen = 0;
  int ack_cyc [N];
  int done_cyc [N];
  int start_cyc = 0;

  function automatic logic [ENT_W-1:0] ent(logic e, int k, logic [W-1:0] r);
    logic [N-1:0] o;
    o    = '0;
    o[k] = 1'b1;
    return {e, o, r};
  endfunction

  function automatic logic [N-1:0] onehot(int k);
    logic [N-1:0] o;
    o    = '0;
    o[k] = 1'b1;
    return o;
  endfunction

  always @(negedge clk) begin
    logic [ENT_W-1:0] ed;
    logic [N-1:0]     ea;
    if (!rst) begin
      if (mif.mont_start) start_cyc = cyc;
      if (ack != '0) begin
        checks++;
        if (exp_ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: got %b, none expected", ack);
        end else begin
          ea = exp_ack_q.pop_front();
          if (ack !== ea) begin
            errors++;
            $display("FAIL ack_order: got %b, expected %b", ack, ea);
          end
        end
        for (int k = 0; k < N; k++) if (ack[k]) ack_cyc[k] = cyc;
      end
      if (done != '0) begin
        checks++;
        done_seen++;
        for (int k = 0; k < N; k++) if (done[k]) done_cyc[k] = cyc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done=%b err=%b result=%0h, none expected",
                   done, err, result);
        end else begin
          ed = exp_q.pop_front();
          if ({err, done, result} !== ed) begin
            errors++;
            $display("FAIL done_resp: got done=%b err=%b result=%0h, expected done=%b err=%b result=%0h",
                     done, err, result, ed[W+N-1:W], ed[ENT_W-1], ed[W-1:0]);
          end
        end
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL err_alone: got err=1 without done, expected 0");
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic chk_i(string name, int got, int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_jobs(string name, int target, int limit);
    int c = 0;
    while (done_seen < target && c < limit) begin
      step(1);
      c++;
    end
    checks++;
    if (done_seen < target) begin
      errors++;
      $display("FAIL %s_timeout: saw %0d done pulses, required %0d within %0d cycles",
               name, done_seen, target, limit);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic set_ops(int k, logic [W-1:0] a, logic [W-1:0] b);
    a_val[k] = a;
    b_val[k] = b;
  endtask

  // ---------------- directed tests ----------------
  int t0, base;

  initial begin
    rst = 1'b1; n_in = '0; spur_done = 1'b0; spur_m = '0;
    for (int k = 0; k < N; k++) begin
      jobs_left[k] = 0; a_val[k] = '0; b_val[k] = '0; ack_cyc[k] = 0; done_cyc[k] = 0;
    end
    step(3);
    rst = 1'b0;
    step(1);

    // reset state
    chk("rst_ack", W'(ack), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_err", W'(err), '0);
    chk("rst_result", result, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_state", W'(state), W'(S_IDLE));
    chk("rst_start", W'(mif.mont_start), '0);
    chk("rst_mont_n", mif.mont_n, '0);
    chk("rst_mont_a", mif.mont_a, '0);
    chk("rst_mont_b", mif.mont_b, '0);

    // 1: single request, latency profile
    n_in = W'(32'h11); lat = 10;
    set_ops(0, W'(5), W'(3));
    exp_ack_q.push_back(onehot(0));
    exp_q.push_back(ent(1'b0, 0, W'(6)));
    base = done_seen; t0 = cyc;
    jobs_left[0] = 1;
    wait_jobs("t1", base + 1, 100);
    chk_i("t1_ack_lat", ack_cyc[0] - t0, 1);
    chk_i("t1_start_lat", start_cyc - t0, 2);
    chk_i("t1_done_lat", done_cyc[0] - t0, 13);
    chk("t1_mont_n", mif.mont_n, W'(32'h11));
    chk("t1_mont_a", mif.mont_a, W'(5));
    chk("t1_mont_b", mif.mont_b, W'(3));

    // 2: simultaneous requests after reset, back-to-back grant
    do_reset();
    set_ops(0, W'(32'h10), W'(32'h01));
    set_ops(1, W'(32'h20), W'(32'h0F));
    for (int r = 0; r < 2; r++) begin
      exp_ack_q.push_back(onehot(0));
      exp_ack_q.push_back(onehot(1));
      exp_q.push_back(ent(1'b0, 0, W'(32'h11)));
      exp_q.push_back(ent(1'b0, 1, W'(32'h2F)));
      base = done_seen;
      jobs_left[0] = 1; jobs_left[1] = 1;
      wait_jobs("t2", base + 2, 200);
      chk_i("t2_b2b_grant", ack_cyc[1] - done_cyc[0], 1);
    end

    // 3: fairness, 20 continuous jobs alternate
    lat = 4;
    set_ops(0, W'(32'hAAAA), W'(32'h0F0F));
    set_ops(1, W'(32'h1234), W'(32'h00FF));
    for (int j = 0; j < 10; j++) begin
      exp_ack_q.push_back(onehot(0));
      exp_ack_q.push_back(onehot(1));
      exp_q.push_back(ent(1'b0, 0, W'(32'hA5A5)));
      exp_q.push_back(ent(1'b0, 1, W'(32'h12CB)));
    end
    base = done_seen;
    jobs_left[0] = 10; jobs_left[1] = 10;
    wait_jobs("t3", base + 20, 400);

    // 4: watchdog abort
    never_done = 1'b1;
    set_ops(0, W'(7), W'(9));
    exp_ack_q.push_back(onehot(0));
    exp_q.push_back(ent(1'b1, 0, '0));
    base = done_seen;
    jobs_left[0] = 1;
    wait_jobs("t4", base + 1, TO + 50);
    chk_i("t4_timeout_lat", done_cyc[0] - start_cyc, TO);
    never_done = 1'b0;

    // 5a: spurious done while idle
    step(2);
    base = done_seen;
    spur_m = W'(32'hBEEF);
    spur_done = 1'b1;
    step(1);
    spur_done = 1'b0;
    step(3);
    chk_i("t5_spur_no_done", done_seen, base);
    chk("t5_spur_result", result, '0);
    chk("t5_spur_busy", W'(busy), '0);

    // 5b: done on the watchdog expiry cycle completes normally
    lat = TO - 1;
    set_ops(0, W'(32'h3C), W'(32'h0F));
    exp_ack_q.push_back(onehot(0));
    exp_q.push_back(ent(1'b0, 0, W'(32'h33)));
    base = done_seen;
    jobs_left[0] = 1;
    wait_jobs("t5", base + 1, TO + 50);
    chk_i("t5_coincident_lat", done_cyc[0] - start_cyc, TO);

    // 6: reset in the middle of a job
    lat = 50;
    set_ops(0, W'(32'h77), W'(32'h11));
    exp_ack_q.push_back(onehot(0));
    base = done_seen;
    jobs_left[0] = 1;
    step(10);
    chk("t6_busy_mid", W'(busy), W'(1));
    chk("t6_state_mid", W'(state), W'(S_WAIT));
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", W'(busy), '0);
    chk("t6_rst_state", W'(state), W'(S_IDLE));
    chk("t6_rst_result", result, '0);
    chk("t6_rst_mont_a", mif.mont_a, '0);
    chk("t6_rst_ack_done", W'({ack, done, err}), '0);
    step(2);
    rst = 1'b0;
    step(60);
    chk_i("t6_no_done", done_seen, base);
    lat = 10;
    set_ops(0, W'(32'hA5), W'(32'h5A));
    exp_ack_q.push_back(onehot(0));
    exp_q.push_back(ent(1'b0, 0, W'(32'hFF)));
    jobs_left[0] = 1;
    wait_jobs("t6", base + 1, 100);

    step(5);
    chk_i("end_exp_q_empty", exp_q.size(), 0);
    chk_i("end_ack_q_empty", exp_ack_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "global timeout");
  end

endmodule
